disp_bin2bcd: RTL

Sequential binary-to-BCD converter (shift-add-3, one bit per cycle) sitting directly upstream of the seven-segment digit multiplexer. It accepts an unsigned binary value with a start strobe and produces a held 16-bit, four-digit packed BCD word (digit 3 in [15:12] down to digit 0 in [3:0]). That word drives the multiplexer's `data` input unchanged. Values above 9999 saturate to 9999 and raise an overflow flag.

---
 rtl/disp_bin2bcd.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/disp_bin2bcd.sv
// Sequential shift-add-3 binary-to-BCD converter feeding the seven-segment digit mux.
// Optional leading-zero blanking of upper digits when DISP_BCD_LZB_EN is defined.
module disp_bin2bcd #(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [BIN_W-1:0] b_q, b_d;
  logic [15:0]      s_q, s_d;
  logic [15:0]      s_adj;
  logic [3:0]       cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [15:0]      bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [13:0]      bin_ext;

  // Nibble-wise correction: each digit >= 5 gets +3 before the shift, no inter-digit carry.
  function automatic logic [15:0] add3(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = r[4*i +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] blank_lz(input logic [15:0] v);
    logic [15:0] r;
    r = v;
`ifdef DISP_BCD_LZB_EN
    if (v[15:12] == 4'd0) begin
      r[15:12] = 4'hF;
      if (v[11:8] == 4'd0) begin
        r[11:8] = 4'hF;
        if (v[7:4] == 4'd0) begin
          r[7:4] = 4'hF;
        end else begin
          r[7:4] = v[7:4];
        end
      end else begin
        r[11:8] = v[11:8];
      end
    end else begin
      r[15:12] = v[15:12];
    end
`endif
    return r;
  endfunction

  assign bin_ext = 14'(bin);

  // Next-state and datapath logic for IDLE/SHIFT/DONE.
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    s_d     = s_q;
    s_adj   = add3(s_q);
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          b_d     = bin;
          s_d     = 16'h0000;
          cnt_d   = 4'(BIN_W);
          sat_d   = (bin_ext > 14'd9999);
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        s_d   = {s_adj[14:0], b_q[BIN_W-1]};
        b_d   = {b_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          bcd_d   = sat_q ? 16'h9999 : blank_lz(s_d);
          ovf_d   = sat_q;
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      b_q     <= '0;
      s_q     <= 16'h0000;
      cnt_q   <= 4'd0;
      sat_q   <= 1'b0;
      bcd_q   <= 16'h0000;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule
